// File: rtl/pe_spike_injector_if.sv
// Spike input, destination-table config and flit output of pe_spike_injector.
// The injector sits on the slave side; the PE/switch environment drives the master side.
interface pe_spike_injector_if;
   logic        i_spike_valid;
   logic        o_spike_ready;
   logic [9:0]  i_spike_id;
   logic        i_tick;
   logic        i_cfg_we;
   logic [3:0]  i_cfg_addr;
   logic [8:0]  i_cfg_data;
   logic        o_pe_valid;
   logic        i_pe_ready;
   logic [41:0] o_pe_data;
   logic        o_busy;

   modport slave (
      input  i_spike_valid,
      output o_spike_ready,
      input  i_spike_id,
      input  i_tick,
      input  i_cfg_we,
      input  i_cfg_addr,
      input  i_cfg_data,
      output o_pe_valid,
      input  i_pe_ready,
      output o_pe_data,
      output o_busy
   );

   modport master (
      output i_spike_valid,
      input  o_spike_ready,
      output i_spike_id,
      output i_tick,
      output i_cfg_we,
      output i_cfg_addr,
      output i_cfg_data,
      input  o_pe_valid,
      output i_pe_ready,
      input  o_pe_data,
      input  o_busy
   );
endinterface

// File: rtl/pe_spike_injector.sv
// Buffers timestamped spike events and fans each one out as flits to every enabled
// destination-table entry, in ascending entry order, one spike at a time.
module pe_spike_injector #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [3:0]  SRC_X      = 4'd0,
   parameter logic [3:0]  SRC_Y      = 4'd0
) (
   input logic                i_clk,
   input logic                i_rst,
   pe_spike_injector_if.slave bus_io
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned EvW  = 26;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StSend
   } state_e;

   logic [EvW-1:0]  fifo_mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   logic [15:0]     ts_q, ts_d;
   logic [8:0]      table_q [16];
   logic [8:0]      entry;

   state_e          state_q;
   logic [3:0]      idx_q;
   logic [9:0]      hold_id_q;
   logic [15:0]     hold_ts_q;
   logic            pe_valid_q;
   logic [41:0]     pe_data_q;

   // A full FIFO refuses pushes even when the FSM pops in the same cycle.
   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus_io.i_spike_valid && !full;
   assign pop   = (state_q == StIdle) && !empty;
   assign entry = table_q[idx_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ts_d     = ts_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
      if (bus_io.i_tick) begin
         ts_d = ts_q + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ts_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ts_q     <= ts_d;
      end
   end

   // Event storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= {bus_io.i_spike_id, ts_q};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) begin
            table_q[i] <= '0;
         end
      end else if (bus_io.i_cfg_we) begin
         table_q[bus_io.i_cfg_addr] <= bus_io.i_cfg_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         hold_id_q  <= '0;
         hold_ts_q  <= '0;
         pe_valid_q <= 1'b0;
         pe_data_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!empty) begin
                  {hold_id_q, hold_ts_q} <= fifo_mem_q[rd_ptr_q];
                  idx_q                  <= '0;
                  state_q                <= StScan;
               end
            end
            StScan: begin
               if (entry[8]) begin
                  pe_data_q  <= {entry[7:4], entry[3:0], SRC_X, SRC_Y, hold_id_q, hold_ts_q};
                  pe_valid_q <= 1'b1;
                  state_q    <= StSend;
               end else if (idx_q == 4'd15) begin
                  state_q <= StIdle;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            StSend: begin
               if (bus_io.i_pe_ready) begin
                  pe_valid_q <= 1'b0;
                  if (idx_q == 4'd15) begin
                     state_q <= StIdle;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     state_q <= StScan;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.o_spike_ready = !full;
   assign bus_io.o_pe_valid    = pe_valid_q;
   assign bus_io.o_pe_data     = pe_data_q;
   assign bus_io.o_busy        = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_pe_spike_injector.sv
// Directed and randomised bench for pe_spike_injector; expected flits come from a
// queue model that expands each accepted spike over the enabled table entries.
module tb_pe_spike_injector;

   localparam logic [3:0] SrcX = 4'd0;
   localparam logic [3:0] SrcY = 4'd0;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [8:0]  m_tbl [16];
   logic [15:0] m_ts;
   logic [41:0] exp_q [$];
   logic [41:0] got_q [$];

   pe_spike_injector_if bus ();

   pe_spike_injector #(
      .FIFO_DEPTH(4),
      .SRC_X     (SrcX),
      .SRC_Y     (SrcY)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus_io(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [41:0] flit(input logic [8:0] e, input logic [9:0] id,
                                        input logic [15:0] ts);
      return {e[7:4], e[3:0], SrcX, SrcY, id, ts};
   endfunction

   // Observe the current cycle, update the model, then advance one clock.
   task automatic step();
      if (rst) begin
         m_ts = '0;
         for (int e = 0; e < 16; e++) m_tbl[e] = '0;
         exp_q.delete();
         got_q.delete();
      end else begin
         if (bus.o_pe_valid && bus.i_pe_ready) got_q.push_back(bus.o_pe_data);
         if (bus.i_cfg_we) m_tbl[bus.i_cfg_addr] = bus.i_cfg_data;
         if (bus.i_spike_valid && bus.o_spike_ready) begin
            for (int e = 0; e < 16; e++) begin
               if (m_tbl[e][8]) exp_q.push_back(flit(m_tbl[e], bus.i_spike_id, m_ts));
            end
         end
         if (bus.i_tick) m_ts = m_ts + 16'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_spike_valid = 1'b0;
      bus.i_spike_id    = '0;
      bus.i_tick        = 1'b0;
      bus.i_cfg_we      = 1'b0;
      bus.i_cfg_addr    = '0;
      bus.i_cfg_data    = '0;
      bus.i_pe_ready    = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [3:0] addr, input logic [8:0] data);
      bus.i_cfg_we   = 1'b1;
      bus.i_cfg_addr = addr;
      bus.i_cfg_data = data;
      step();
      bus.i_cfg_we   = 1'b0;
   endtask

   task automatic send_spike(input logic [9:0] id);
      bus.i_spike_valid = 1'b1;
      bus.i_spike_id    = id;
      step();
      bus.i_spike_valid = 1'b0;
   endtask

   task automatic drain(input int max_cycles, output bit timed_out);
      int n = 0;
      while ((bus.o_busy || bus.o_pe_valid) && n < max_cycles) begin
         step();
         n++;
      end
      timed_out = bus.o_busy || bus.o_pe_valid;
   endtask

   task automatic wait_valid(input int max_cycles, output bit timed_out);
      int n = 0;
      while (!bus.o_pe_valid && n < max_cycles) begin
         step();
         n++;
      end
      timed_out = !bus.o_pe_valid;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.o_pe_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_pe_valid got=%0b want=0", bus.o_pe_valid);
      end
      checks++;
      if (bus.o_pe_data !== 42'h0) begin
         failures++;
         $display("FAIL reset_pe_data got=%0h want=0", bus.o_pe_data);
      end
      checks++;
      if (bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%0b want=0", bus.o_busy);
      end
      checks++;
      if (bus.o_spike_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_spike_ready got=%0b want=1", bus.o_spike_ready);
      end
   endtask

   task automatic test_two_entries();
      bit to;
      do_reset();
      cfg_write(4'd2, {1'b1, 4'd1, 4'd1});
      cfg_write(4'd9, {1'b1, 4'd3, 4'd0});
      bus.i_tick = 1'b1;
      repeat (3) step();
      bus.i_tick     = 1'b0;
      bus.i_pe_ready = 1'b1;
      send_spike(10'h005);
      drain(100, to);
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL two_entries_timeout got=busy want=idle");
      end
      checks++;
      if (got_q.size() != 2) begin
         failures++;
         $display("FAIL two_entries_count got=%0d want=2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL two_entries_flit%0d got=%0h want=%0h", i, got_q[i], exp_q[i]);
         end
      end
      if (got_q.size() == 2) begin
         checks++;
         if (got_q[0] !== 42'h4400050003) begin
            failures++;
            $display("FAIL two_entries_lit0 got=%0h want=4400050003", got_q[0]);
         end
         checks++;
         if (got_q[1] !== 42'hC000050003) begin
            failures++;
            $display("FAIL two_entries_lit1 got=%0h want=c000050003", got_q[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit          to;
      logic [41:0] held;
      do_reset();
      cfg_write(4'd2, {1'b1, 4'd1, 4'd1});
      cfg_write(4'd9, {1'b1, 4'd3, 4'd0});
      bus.i_tick = 1'b1;
      repeat (3) step();
      bus.i_tick     = 1'b0;
      bus.i_pe_ready = 1'b0;
      send_spike(10'h005);
      wait_valid(40, to);
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL bp_first_valid got=0 want=1");
      end
      held = bus.o_pe_data;
      checks++;
      if (exp_q.size() == 0 || held !== exp_q[0]) begin
         failures++;
         $display("FAIL bp_first_flit got=%0h want=model", held);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.o_pe_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_valid_hold%0d got=%0b want=1", i, bus.o_pe_valid);
         end
         checks++;
         if (bus.o_pe_data !== held) begin
            failures++;
            $display("FAIL bp_data_hold%0d got=%0h want=%0h", i, bus.o_pe_data, held);
         end
         step();
      end
      bus.i_pe_ready = 1'b1;
      step();
      checks++;
      if (bus.o_pe_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_valid_drop got=%0b want=0", bus.o_pe_valid);
      end
      drain(100, to);
      checks++;
      if (got_q.size() != 2 || exp_q.size() != 2) begin
         failures++;
         $display("FAIL bp_count got=%0d want=2", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL bp_flit%0d got=%0h want=%0h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_fifo_full();
      bit to;
      bit acc;
      int n;
      do_reset();
      cfg_write(4'd0, {1'b1, 4'd2, 4'd5});
      bus.i_pe_ready    = 1'b0;
      bus.i_spike_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.i_spike_id = 10'(100 + i);
         checks++;
         if (bus.o_spike_ready !== 1'(i < 5)) begin
            failures++;
            $display("FAIL fifo_ready%0d got=%0b want=%0b", i, bus.o_spike_ready, i < 5);
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.o_spike_ready !== 1'b0) begin
            failures++;
            $display("FAIL fifo_stall%0d got=%0b want=0", i, bus.o_spike_ready);
         end
         step();
      end
      bus.i_pe_ready = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 40) begin
         acc = bus.o_spike_ready;
         step();
         n++;
      end
      bus.i_spike_valid = 1'b0;
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL fifo_sixth_accept got=0 want=1");
      end
      drain(400, to);
      checks++;
      if (to !== 1'b0 || got_q.size() != 6) begin
         failures++;
         $display("FAIL fifo_count got=%0d want=6", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL fifo_flit%0d got=%0h want=%0h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_all_disabled();
      int first_low = -1;
      bit seen_valid = 1'b0;
      do_reset();
      bus.i_pe_ready = 1'b1;
      send_spike(10'($urandom));
      for (int n = 1; n <= 40; n++) begin
         if (!bus.o_busy && first_low < 0) first_low = n;
         if (bus.o_pe_valid) seen_valid = 1'b1;
         step();
      end
      checks++;
      if (first_low != 18) begin
         failures++;
         $display("FAIL disabled_busy_drop got=%0d want=18", first_low);
      end
      checks++;
      if (seen_valid !== 1'b0 || got_q.size() != 0) begin
         failures++;
         $display("FAIL disabled_no_flit got=%0d want=0", got_q.size());
      end
   endtask

   task automatic test_table_write_mid();
      bit to;
      do_reset();
      cfg_write(4'd3, {1'b1, 4'd1, 4'd2});
      cfg_write(4'd12, {1'b1, 4'd4, 4'd5});
      bus.i_pe_ready = 1'b0;
      send_spike(10'h02A);
      wait_valid(40, to);
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL midwrite_valid got=0 want=1");
      end
      cfg_write(4'd3, {1'b1, 4'd9, 4'd9});
      cfg_write(4'd2, {1'b1, 4'd8, 4'd8});
      cfg_write(4'd7, {1'b1, 4'd6, 4'd6});
      // Entry 3 was already loaded and entry 2 already scanned; only entry 7 joins in.
      exp_q.delete();
      exp_q.push_back(flit({1'b1, 4'd1, 4'd2}, 10'h02A, 16'h0));
      exp_q.push_back(flit({1'b1, 4'd6, 4'd6}, 10'h02A, 16'h0));
      exp_q.push_back(flit({1'b1, 4'd4, 4'd5}, 10'h02A, 16'h0));
      bus.i_pe_ready = 1'b1;
      drain(100, to);
      checks++;
      if (to !== 1'b0 || got_q.size() != 3) begin
         failures++;
         $display("FAIL midwrite_count got=%0d want=3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL midwrite_flit%0d got=%0h want=%0h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_send();
      bit to;
      do_reset();
      cfg_write(4'd4, {1'b1, 4'd2, 4'd3});
      bus.i_pe_ready = 1'b0;
      send_spike(10'h011);
      wait_valid(40, to);
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_valid got=0 want=1");
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.o_pe_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_abort got=valid%0b_busy%0b want=valid0_busy0",
                  bus.o_pe_valid, bus.o_busy);
      end
      checks++;
      if (bus.o_pe_data !== 42'h0 || bus.o_spike_ready !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_outputs got=%0h/%0b want=0/1", bus.o_pe_data, bus.o_spike_ready);
      end
      bus.i_pe_ready = 1'b1;
      send_spike(10'h022);
      drain(60, to);
      checks++;
      if (to !== 1'b0 || got_q.size() != 0) begin
         failures++;
         $display("FAIL rstmid_table_cleared got=%0d want=0", got_q.size());
      end
   endtask

   task automatic test_random();
      bit to;
      for (int r = 0; r < 2; r++) begin
         do_reset();
         for (int e = 0; e < 16; e++) begin
            cfg_write(4'(e), {($urandom_range(0, 2) == 0), 8'($urandom)});
         end
         for (int c = 0; c < 300; c++) begin
            bus.i_spike_valid = 1'($urandom_range(0, 1));
            bus.i_spike_id    = 10'($urandom);
            bus.i_tick        = ($urandom_range(0, 3) == 0);
            bus.i_pe_ready    = ($urandom_range(0, 3) != 0);
            step();
         end
         idle_inputs();
         bus.i_pe_ready = 1'b1;
         drain(3000, to);
         checks++;
         if (to !== 1'b0 || got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random%0d_count got=%0d want=%0d", r, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL random%0d_flit%0d got=%0h want=%0h", r, i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_ts_wrap();
      bit to;
      do_reset();
      cfg_write(4'd5, {1'b1, 4'd7, 4'd9});
      bus.i_tick = 1'b1;
      repeat (65535) step();
      step();
      bus.i_tick     = 1'b0;
      bus.i_pe_ready = 1'b1;
      send_spike(10'h3FF);
      drain(60, to);
      checks++;
      if (to !== 1'b0 || got_q.size() != 1) begin
         failures++;
         $display("FAIL tswrap_count got=%0d want=1", got_q.size());
      end
      if (got_q.size() == 1) begin
         checks++;
         if (got_q[0][15:0] !== 16'h0000) begin
            failures++;
            $display("FAIL tswrap_field got=%0h want=0", got_q[0][15:0]);
         end
         checks++;
         if (exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL tswrap_flit got=%0h want=model", got_q[0]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle_inputs();
      test_reset();
      test_two_entries();
      test_backpressure();
      test_fifo_full();
      test_all_disabled();
      test_table_write_mid();
      test_reset_mid_send();
      test_random();
      test_ts_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
